// File: rtl/display_pkg.sv
// Shared constants for the sale-terminal seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

   localparam int NUM_DIGITS = 5;

   localparam logic [19:0] BCD_OVERFLOW = 20'hFFFFF;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Glyph for a single BCD nibble; non-decimal codes render blank.
   function automatic logic [6:0] bcd_glyph(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with dash and blank overrides.
// Dash wins over blank, blank wins over the nibble glyph.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = bcd_glyph(nibble);
      if (dash) begin
         seg_n = SEG_DASH;
      end else if (blank) begin
         seg_n = SEG_BLANK;
      end
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Five-digit multiplexed seven-segment driver with a BCD shadow register.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scan
   import display_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = NUM_DIGITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                bcd_valid,
   output logic [6:0]          seg_n,
   output logic [DIGITS-1:0]   an_n,
   output logic                busy
);

   localparam int               PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow_reg;
   logic [PRE_W-1:0]    pre_reg;
   logic [PRE_W-1:0]    pre_next;
   logic [2:0]          idx_reg;
   logic [2:0]          idx_next;
   logic [6:0]          seg_n_reg;
   logic [6:0]          seg_n_next;
   logic [DIGITS-1:0]   an_n_reg;
   logic [DIGITS-1:0]   an_n_next;
   logic                busy_reg;

   logic [3:0]          nib [DIGITS];
   logic [DIGITS-1:0]   lz_mask;
   logic [3:0]          sel_nib;
   logic                sel_blank;
   logic                overflow;

   // Digit k is a leading zero when it and every more significant nibble is 0.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nib[gi] = shadow_reg[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign lz_mask[gi] = 1'b0;
         end else begin : g_upper
`ifdef LEADING_ZERO_BLANK_EN
            assign lz_mask[gi] = (shadow_reg[4*DIGITS-1 : 4*gi] == '0);
`else
            assign lz_mask[gi] = 1'b0;
`endif
         end
      end
   endgenerate

   assign sel_nib   = nib[idx_reg];
   assign sel_blank = lz_mask[idx_reg];
   assign overflow  = (shadow_reg == BCD_OVERFLOW);

   seg7_decode u_decode (
      .nibble (sel_nib),
      .blank  (sel_blank),
      .dash   (overflow),
      .seg_n  (seg_n_next)
   );

   always_comb begin
      pre_next  = pre_reg + 1'b1;
      idx_next  = idx_reg;
      if (pre_reg == PRE_LAST) begin
         pre_next = '0;
         idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
      end
      // Anodes stay dark for the first cycle of each slot to hide segment changes.
      an_n_next = '1;
      if (pre_reg != '0) begin
         an_n_next = ~(DIGITS'(1) << idx_reg);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_reg <= '0;
         pre_reg    <= '0;
         idx_reg    <= 3'd0;
         seg_n_reg  <= SEG_BLANK;
         an_n_reg   <= '1;
         busy_reg   <= 1'b0;
      end else begin
         if (bcd_valid) begin
            shadow_reg <= bcd_in;
         end
         pre_reg   <= pre_next;
         idx_reg   <= idx_next;
         seg_n_reg <= seg_n_next;
         an_n_reg  <= an_n_next;
         busy_reg  <= bcd_valid;
      end
   end

   assign seg_n = seg_n_reg;
   assign an_n  = an_n_reg;
   assign busy  = busy_reg;

endmodule
